// File: rtl/adder_pkg.sv
// Shared helpers and per-stage control type for the pipelined slice adder.
// Stage count and the legality check for WIDTH/SLICE pairs live here.
package adder_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned DefaultSlice = 4;

    function automatic int unsigned nstg(input int unsigned width, input int unsigned slice);
        return width / slice;
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned slice);
        return (slice != 0) && (width >= slice) && ((width % slice) == 0);
    endfunction

    localparam bit DefaultParamsOk = params_ok(DefaultWidth, DefaultSlice);

    // Control half of a stage payload; the data half is width-dependent and
    // is declared alongside it in the top module.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctrl_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple-carry adder used as the per-stage arithmetic.
module adder_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             ci,
    output logic [SLICE-1:0] sum,
    output logic             co
);

    logic [SLICE:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = ci;
        for (int i = 0; i < SLICE; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        co = c[SLICE];
    end

endmodule

// File: rtl/pipelined_slice_adder.sv
// Pipelined WIDTH-bit add/subtract: one SLICE-bit ripple slice per stage, carry and
// operand skew registered between stages, valid/ready handshake with bubble collapse.
module pipelined_slice_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned SLICE = DefaultSlice
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   s,
    output logic             ovf
);

    localparam int unsigned NSTG = nstg(WIDTH, SLICE);

    if (!params_ok(WIDTH, SLICE)) begin : gen_param_check
        $error("pipelined_slice_adder: WIDTH must be a non-zero multiple of SLICE");
    end

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [NSTG-1:0]  valid_vec;
    logic [NSTG-1:0]  load;

    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? 1'b1 : cin;

    for (genvar k = 0; k < NSTG; k++) begin : gen_stage
        stage_ctrl_t      ctl_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] sum_q;

        logic [WIDTH-1:0] x_in;
        logic [WIDTH-1:0] y_in;
        logic [WIDTH-1:0] sum_in;
        logic [WIDTH-1:0] sum_nxt;
        logic             c_in;
        logic             v_in;
        logic [SLICE-1:0] slice_sum;
        logic             slice_co;

        if (k == 0) begin : gen_first
            assign x_in   = a;
            assign y_in   = b_eff;
            assign c_in   = c0;
            assign v_in   = in_valid;
            assign sum_in = '0;
        end else begin : gen_next
            assign x_in   = gen_stage[k-1].a_q;
            assign y_in   = gen_stage[k-1].b_q;
            assign c_in   = gen_stage[k-1].ctl_q.carry;
            assign v_in   = gen_stage[k-1].ctl_q.valid;
            assign sum_in = gen_stage[k-1].sum_q;
        end

        adder_slice #(
            .SLICE(SLICE)
        ) u_slice (
            .x  (x_in[k*SLICE +: SLICE]),
            .y  (y_in[k*SLICE +: SLICE]),
            .ci (c_in),
            .sum(slice_sum),
            .co (slice_co)
        );

        always_comb begin
            sum_nxt                    = sum_in;
            sum_nxt[k*SLICE +: SLICE] = slice_sum;
        end

        assign valid_vec[k] = ctl_q.valid;
        // A stage can load if it or any stage downstream of it has a hole,
        // or the output is being drained this cycle.
        assign load[k] = out_ready | ~(&valid_vec[NSTG-1:k]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctl_q <= '0;
                a_q   <= '0;
                b_q   <= '0;
                sum_q <= '0;
            end else if (load[k]) begin
                ctl_q.valid <= v_in;
                ctl_q.carry <= slice_co;
                a_q         <= x_in;
                b_q         <= y_in;
                sum_q       <= sum_nxt;
            end
        end
    end

    logic [WIDTH-1:0] last_sum;
    logic             last_a_msb;
    logic             last_b_msb;

    assign last_sum   = gen_stage[NSTG-1].sum_q;
    assign last_a_msb = gen_stage[NSTG-1].a_q[WIDTH-1];
    assign last_b_msb = gen_stage[NSTG-1].b_q[WIDTH-1];

    assign in_ready  = load[0];
    assign out_valid = gen_stage[NSTG-1].ctl_q.valid;
    assign s         = {gen_stage[NSTG-1].ctl_q.carry, last_sum};
    assign ovf       = (last_a_msb == last_b_msb) && (last_sum[WIDTH-1] != last_a_msb);

endmodule

// File: tb/tb_pipelined_slice_adder.sv
// Directed-vector and scoreboard bench for pipelined_slice_adder (16/4 main instance,
// plus 32/8 and 8/8 instances for the parameter sweep).
module tb_pipelined_slice_adder;

    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, ovf;
    logic [15:0] a, b;
    logic [16:0] s;

    logic        iv32, ir32, cin32, sub32, ov32, ovf32;
    logic [31:0] a32, b32;
    logic [32:0] s32;
    logic        iv8, ir8, cin8, sub8, ov8, ovf8;
    logic [7:0]  a8, b8;
    logic [8:0]  s8;

    always #5 clk = ~clk;

    pipelined_slice_adder #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .s(s), .ovf(ovf)
    );

    pipelined_slice_adder #(.WIDTH(32), .SLICE(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(1'b1), .s(s32), .ovf(ovf32)
    );

    pipelined_slice_adder #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(1'b1), .s(s8), .ovf(ovf8)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [16:0] s;
        logic        ovf;
    } vec_t;

    vec_t        tbl[10];
    int          vectors = 0;
    int          miscompares = 0;
    int          acc_cnt = 0;
    int          got_cnt = 0;
    logic [17:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: carry/borrow from unsigned compare, overflow from integer range.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
        logic [16:0] r;
        int          sr;
        if (sb) begin
            r[15:0] = x - y;
            r[16]   = (x >= y);
            sr      = int'($signed(x)) - int'($signed(y));
        end else begin
            r  = {1'b0, x} + {1'b0, y} + {16'd0, ci};
            sr = int'($signed(x)) + int'($signed(y)) + int'(ci);
        end
        return {(sr > 32767) || (sr < -32768), r};
    endfunction

    task automatic run_single(input vec_t v, input string tag);
        int cyc;
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(NS - 1));
        check({tag, "_s"}, 64'(s), 64'(v.s));
        check({tag, "_ovf"}, 64'(ovf), 64'(v.ovf));
        @(posedge clk);
        #1;
    endtask

    // One cycle: drive on negedge, sample 1ns before the rising edge.
    task automatic step(input bit iv, input bit ordy);
        logic [17:0] e;
        @(negedge clk);
        in_valid = iv; out_ready = ordy;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        #4;
        if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, cin, sub));
            acc_cnt++;
        end
        if (out_valid && out_ready) begin
            got_cnt++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL extra_beat: got %0h, expected no beat", {ovf, s});
            end else begin
                e = exp_q.pop_front();
                check("stream_beat", 64'({ovf, s}), 64'(e));
            end
        end
    endtask

    task automatic stream(input int n, input bit rnd, input int cap, output int cycles);
        acc_cnt = 0; got_cnt = 0; cycles = 0;
        while ((acc_cnt < n || got_cnt < n) && cycles < cap) begin
            step((acc_cnt < n) && (rnd ? ($urandom_range(3) != 0) : 1'b1),
                 rnd ? ($urandom_range(2) != 0) : 1'b1);
            cycles++;
        end
        check("stream_accepted", 64'(acc_cnt), 64'(n));
        check("stream_delivered", 64'(got_cnt), 64'(n));
        check("stream_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        vec_t v;
        tbl[0] = '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 17'h02201, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0};
        tbl[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE, 1'b0};
        tbl[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1};
        tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1};
        tbl[5] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 17'h00003, 1'b0};
        tbl[6] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 17'h1000D, 1'b0};
        tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000, 1'b1};
        tbl[8] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 17'h10000, 1'b0};
        tbl[9] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 17'h08000, 1'b1};

        in_valid = 0; out_ready = 1; a = 0; b = 0; cin = 0; sub = 0;
        iv32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0;
        iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;

        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_s", 64'(s), 64'd0);
        check("reset_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("reset_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 10; i++) run_single(tbl[i], $sformatf("vec%0d", i));

        // Full-rate streaming: 100 beats drain in 100 + NS sampled cycles.
        stream(100, 1'b0, 1000, cyc);
        check("b2b_cycles", 64'(cyc), 64'(100 + NS));

        // Backpressure from empty: exactly NS beats fit, head result holds.
        acc_cnt = 0; got_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0);
            if (i == 5 || i == 10) begin
                check("stall_out_valid", 64'(out_valid), 64'd1);
                check("stall_head", 64'({ovf, s}), 64'(exp_q[0]));
            end
        end
        check("stall_accepts", 64'(acc_cnt), 64'(NS));
        check("stall_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        check("full_accept_emit", 64'(acc_cnt), 64'(NS + 3));
        cyc = 0;
        while (got_cnt < acc_cnt && cyc < 50) begin
            step(1'b0, 1'b1);
            cyc++;
        end
        check("stall_delivered", 64'(got_cnt), 64'(NS + 3));
        check("stall_queue_empty", 64'(exp_q.size()), 64'd0);

        stream(1000, 1'b1, 20000, cyc);

        // Asynchronous reset with three beats in flight.
        acc_cnt = 0; got_cnt = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        @(posedge clk);
        #1 check("pre_reset_out_valid", 64'(out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", 64'(out_valid), 64'd0);
        check("async_reset_s", 64'(s), 64'd0);
        check("async_reset_ovf", 64'(ovf), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_single(tbl[3], "post_reset");

        // 32/8 instance: NSTG = 4.
        @(negedge clk);
        a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; iv32 = 1'b1;
        check("w32_in_ready", 64'(ir32), 64'd1);
        @(posedge clk);
        #1 iv32 = 1'b0;
        cyc = 0;
        while (!ov32 && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("w32_latency", 64'(cyc), 64'd3);
        check("w32_s", 64'(s32), 64'h0_8000_0000);
        check("w32_ovf", 64'(ovf32), 64'd1);

        // 8/8 instance: single stage.
        @(negedge clk);
        a8 = 8'h7F; b8 = 8'h01; iv8 = 1'b1;
        check("w8_in_ready", 64'(ir8), 64'd1);
        @(posedge clk);
        #1 iv8 = 1'b0;
        cyc = 0;
        while (!ov8 && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("w8_latency", 64'(cyc), 64'd0);
        check("w8_s", 64'(s8), 64'h080);
        check("w8_ovf", 64'(ovf8), 64'd1);

        v = tbl[0];
        if (v.a != 16'h1234) check("table_intact", 64'(v.a), 64'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
